priority_encoder_seq: RTL and testbench

- Registered priority encoder; the inverse of the 2-to-4 decoder. It converts one-hot/multi-hot request lines back into a binary index.
- Requests are captured into a sticky pending register. Each pending request is issued as a binary code through a valid/ready output handshake, one code per transfer.
- Sits on the input of the decoder path. Downstream logic consumes codes at its own rate.

---
 rtl/priority_encoder_seq.sv | 108 ++++++++++
 tb/tb_priority_encoder_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_seq.sv
// Purpose : sticky pending-request register that issues one binary code per valid/ready transfer.
// Latency : request sampled at edge N is visible in pending after N, and is issued on y/valid at edge N+1 if the output is free.
// Backpress: while valid && !ready, y/valid hold and new requests keep merging into pending.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   en, d          request capture enable and request lines (d[i] requests code i)
//   ready          downstream accepts y when valid=1
//   y, valid       registered code and its valid flag
//   pending        registered pending-request bits
//   busy           valid OR any request pending (combinational)
//
// Optional build macro: PRIORITY_ROUND_ROBIN_EN selects a rotating-pointer
// arbiter instead of fixed lowest-index priority.
// WIDTH must be a power of 2 (>= 2) so the index arithmetic wraps naturally.
module priority_encoder_seq #(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [0:WIDTH-1]           d,
   input  logic                       ready,
   output logic [$clog2(WIDTH)-1:0]   y,
   output logic                       valid,
   output logic [0:WIDTH-1]           pending,
   output logic                       busy
);

   localparam int CODE_W = $clog2(WIDTH);

   logic [CODE_W-1:0] sel_idx;
   logic              out_free;
   logic              load;
   logic [0:WIDTH-1]  clear_onehot;
   logic [0:WIDTH-1]  pending_next;

`ifdef PRIORITY_ROUND_ROBIN_EN
   logic [CODE_W-1:0] ptr;
   logic [CODE_W-1:0] scan_idx;

   // Scan from the farthest offset down to offset 0 so the last write
   // (smallest offset from ptr) wins; CODE_W-wide addition wraps mod WIDTH.
   always_comb begin
      sel_idx  = '0;
      scan_idx = '0;
      for (int off = WIDTH - 1; off >= 0; off--) begin
         scan_idx = ptr + CODE_W'(off);
         if (pending[scan_idx]) begin
            sel_idx = scan_idx;
         end
      end
   end
`else
   // Descending scan: the lowest set index is written last and wins.
   always_comb begin
      sel_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_idx = CODE_W'(i);
         end
      end
   end
`endif

   assign out_free = !valid || ready;
   assign load     = out_free && (pending != '0);

   always_comb begin
      clear_onehot = '0;
      if (load) begin
         clear_onehot[sel_idx] = 1'b1;
      end
   end

   // Set after clear: a re-request of the bit being issued stays pending.
   assign pending_next = (pending & ~clear_onehot) | (en ? d : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         valid   <= 1'b0;
         y       <= '0;
      end else begin
         pending <= pending_next;
         if (load) begin
            y     <= sel_idx;
            valid <= 1'b1;
         end else if (out_free) begin
            // Nothing to issue: drop valid, keep the last code on y.
            valid <= 1'b0;
         end
      end
   end

`ifdef PRIORITY_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= sel_idx + CODE_W'(1);
      end
   end
`endif

   assign busy = valid || (pending != '0);

endmodule

// File: tb/tb_priority_encoder_seq.sv
module tb_priority_encoder_seq;

   localparam int WIDTH  = 4;
   localparam int CODE_W = 2;

   logic              clk;
   logic              rst;
   logic              en;
   logic [0:WIDTH-1]  d;
   logic              ready;
   logic [CODE_W-1:0] y;
   logic              valid;
   logic [0:WIDTH-1]  pending;
   logic              busy;

   int n_tests;
   int n_fail;

   priority_encoder_seq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .d       (d),
      .ready   (ready),
      .y       (y),
      .valid   (valid),
      .pending (pending),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Request/pending masks in the table use bit i == request line i.
   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] d;
      logic       ready;
      logic [1:0] exp_y;
      logic       exp_valid;
      logic [3:0] exp_pending;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [18];

   task automatic drive(input logic r, input logic e, input logic [3:0] m, input logic rd);
      rst   = r;
      en    = e;
      ready = rd;
      for (int i = 0; i < WIDTH; i++) d[i] = m[i];
   endtask

   function automatic logic [3:0] pend_mask();
      logic [3:0] m;
      for (int i = 0; i < WIDTH; i++) m[i] = pending[i];
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] ey, input logic ev,
                        input logic [3:0] ep, input logic eb);
      logic [3:0] ap;
      ap = pend_mask();
      n_tests++;
      if (y !== ey) begin
         n_fail++;
         $display("FAIL %s y: got %0d expected %0d", name, y, ey);
      end
      n_tests++;
      if (valid !== ev) begin
         n_fail++;
         $display("FAIL %s valid: got %0b expected %0b", name, valid, ev);
      end
      n_tests++;
      if (ap !== ep) begin
         n_fail++;
         $display("FAIL %s pending(line3..0): got %b expected %b", name, ap, ep);
      end
      n_tests++;
      if (busy !== eb) begin
         n_fail++;
         $display("FAIL %s busy: got %0b expected %0b", name, busy, eb);
      end
   endtask

   initial begin
      logic [1:0] rr_exp;
      n_tests = 0;
      n_fail  = 0;
      drive(1'b1, 1'b0, 4'b0000, 1'b0);

      //               rst   en    d        ready  y     v     pending  busy
      // reset, then build pending=1111/valid=1 and reset over it
      vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b1111, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b1111, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
      // single request on line 2
      vecs[4]  = '{1'b0, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b0, 4'b0100, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
      // en=0 gating: requests ignored, y holds last code
      vecs[7]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
      // multi-hot lines 0,2,3 with 3 cycles of backpressure
      vecs[10] = '{1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 4'b1101, 1'b0, 2'd0, 1'b0, 4'b1101, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1100, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1100, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1100, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b1000, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0};

      @(negedge clk);
      for (int k = 0; k < 18; k++) begin
         drive(vecs[k].rst, vecs[k].en, vecs[k].d, vecs[k].ready);
         tick();
         check($sformatf("vec%0d", k), vecs[k].exp_y, vecs[k].exp_valid,
               vecs[k].exp_pending, vecs[k].exp_busy);
      end

      // set/clear collision on line 2
      drive(1'b0, 1'b1, 4'b0100, 1'b1);
      tick();
      check("coll_set", 2'd3, 1'b0, 4'b0100, 1'b1);
      drive(1'b0, 1'b1, 4'b0100, 1'b1);   // re-request in the load cycle
      tick();
      check("coll_load", 2'd2, 1'b1, 4'b0100, 1'b1);
      drive(1'b0, 1'b0, 4'b0000, 1'b1);
      tick();
      check("coll_second", 2'd2, 1'b1, 4'b0000, 1'b1);
      tick();
      check("coll_idle", 2'd2, 1'b0, 4'b0000, 1'b0);

      // all lines held: arbitration order
      drive(1'b1, 1'b0, 4'b0000, 1'b0);
      tick();
      check("arb_reset", 2'd0, 1'b0, 4'b0000, 1'b0);
      drive(1'b0, 1'b1, 4'b1111, 1'b1);
      tick();
      check("arb_fill", 2'd0, 1'b0, 4'b1111, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick();
`ifdef PRIORITY_ROUND_ROBIN_EN
         rr_exp = 2'(k % 4);
`else
         rr_exp = 2'd0;
`endif
         check($sformatf("arb%0d", k), rr_exp, 1'b1, 4'b1111, 1'b1);
      end

      drive(1'b1, 1'b0, 4'b0000, 1'b0);
      tick();
      check("final_reset", 2'd0, 1'b0, 4'b0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
